// File: rtl/stopwatch_core.sv
// BCD stopwatch/timer core: single-clock digit cascade with up/down counting,
// tick prescaler, lap capture with display freeze and a run/pause/done FSM.
module stopwatch_core #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 1
) (
    input  logic                          clk_1Khz,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          mode,
    input  logic                          load,
    input  logic [4*(MIN_DIGITS+5)-1:0]   preset,
    input  logic                          lap,
    input  logic                          lap_clr,
    output logic [4*(MIN_DIGITS+5)-1:0]   count,
    output logic [4*(MIN_DIGITS+4)-1:0]   dispbuf,
    output logic [1:0]                    state,
    output logic                          done,
    output logic                          wrap,
    output logic                          frozen
);

    localparam int N  = MIN_DIGITS + 5;
    localparam int W  = 4 * N;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         cur_state, nxt_state;
    logic [W-1:0]   count_next, lap_reg, inc_val, dec_val;
    logic [PW-1:0]  pre, pre_next;
    logic           done_next, wrap_next, inc_carry, tick;

    // Digit 4 (counting from msec0) is the tens-of-seconds digit.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 4) ? 4'd5 : 4'd9;
    endfunction

    // Returns {carry_out, value}; carry_out set only when rolling over from all-max.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (c) begin
                if (r[4*i +: 4] >= digit_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Saturates at zero rather than underflowing.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = (v != '0);
        for (int i = 0; i < N; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < N; i++) begin
            if (r[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
        end
        return r;
    endfunction

    assign {inc_carry, inc_val} = bcd_inc(count);
    assign dec_val = bcd_dec(count);
    assign tick    = (cur_state == RUN) && (pre == PRE_LAST) && !load;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt_state  = cur_state;
        count_next = count;
        done_next  = done;
        wrap_next  = 1'b0;
        pre_next   = pre;

        if (load) begin
            count_next = sanitise(preset);
            done_next  = 1'b0;
            pre_next   = '0;
            nxt_state  = en ? RUN : PAUSE;
        end else begin
            unique case (cur_state)
                IDLE:    if (en) nxt_state = RUN;
                RUN: begin
                    if (!en) nxt_state = PAUSE;
                    if (tick) begin
                        if (mode) begin
                            count_next = dec_val;
                            if (dec_val == '0) begin
                                nxt_state = DONE;
                                done_next = 1'b1;
                            end
                        end else begin
                            count_next = inc_val;
                            wrap_next  = inc_carry;
                        end
                    end
                end
                PAUSE:   if (en) nxt_state = RUN;
                DONE:    ;
                default: nxt_state = IDLE;
            endcase

            // Prescaler only advances while staying in RUN; zero otherwise.
            if (nxt_state == RUN && cur_state == RUN)
                pre_next = (pre == PRE_LAST) ? '0 : pre + 1'b1;
            else
                pre_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_1Khz or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            count     <= '0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            pre       <= '0;
            lap_reg   <= '0;
            frozen    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            count     <= count_next;
            done      <= done_next;
            wrap      <= wrap_next;
            pre       <= pre_next;
            if (lap_clr) begin
                frozen <= 1'b0;
            end else if (lap) begin
                lap_reg <= count;
                frozen  <= 1'b1;
            end
        end
    end

    assign state   = cur_state;
    assign dispbuf = frozen ? lap_reg[W-1:4] : count[W-1:4];

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: expectations are queued as stimulus is
// driven and popped against the DUT outputs after the relevant clock edges.
module tb_stopwatch_core;

    localparam int S_COUNT  = 0;
    localparam int S_DISP   = 1;
    localparam int S_STATE  = 2;
    localparam int S_DONE   = 3;
    localparam int S_WRAP   = 4;
    localparam int S_FROZEN = 5;
    localparam int S_COUNT4 = 6;
    localparam int S_WRAP4  = 7;
    localparam int S_STATE4 = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [27:0] value;
    } item_t;

    logic        clk_1Khz = 1'b0;
    logic        rst, en, mode, load, lap, lap_clr;
    logic [27:0] preset;
    logic [27:0] count, count4;
    logic [23:0] dispbuf, dispbuf4;
    logic [1:0]  state, state4;
    logic        done, wrap, frozen, done4, wrap4, frozen4;

    item_t sb[$];
    int    n_asserts = 0;
    int    n_fail    = 0;

    stopwatch_core #(.MIN_DIGITS(2), .TICK_DIV(1)) dut (
        .clk_1Khz(clk_1Khz), .rst(rst), .en(en), .mode(mode), .load(load),
        .preset(preset), .lap(lap), .lap_clr(lap_clr), .count(count),
        .dispbuf(dispbuf), .state(state), .done(done), .wrap(wrap), .frozen(frozen)
    );

    stopwatch_core #(.MIN_DIGITS(2), .TICK_DIV(4)) dut4 (
        .clk_1Khz(clk_1Khz), .rst(rst), .en(en), .mode(mode), .load(load),
        .preset(preset), .lap(lap), .lap_clr(lap_clr), .count(count4),
        .dispbuf(dispbuf4), .state(state4), .done(done4), .wrap(wrap4), .frozen(frozen4)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    function automatic logic [27:0] observe(input int sel);
        case (sel)
            S_COUNT:  return count;
            S_DISP:   return {4'h0, dispbuf};
            S_STATE:  return {26'h0, state};
            S_DONE:   return {27'h0, done};
            S_WRAP:   return {27'h0, wrap};
            S_FROZEN: return {27'h0, frozen};
            S_COUNT4: return count4;
            S_WRAP4:  return {27'h0, wrap4};
            S_STATE4: return {26'h0, state4};
            default:  return 28'hxxxxxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [27:0] value);
        item_t it;
        it.tag   = tag;
        it.sel   = sel;
        it.value = value;
        sb.push_back(it);
    endtask

    task automatic check();
        item_t       it;
        logic [27:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel);
            n_asserts++;
            assert (obs === it.value) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.value);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1Khz);
        @(negedge clk_1Khz);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0;
        lap = 1'b0; lap_clr = 1'b0; preset = '0;
        step(2);
        expect_val("rst_count", S_COUNT, 28'h0);
        expect_val("rst_disp", S_DISP, 28'h0);
        expect_val("rst_state", S_STATE, 28'h0);
        expect_val("rst_done", S_DONE, 28'h0);
        expect_val("rst_wrap", S_WRAP, 28'h0);
        expect_val("rst_frozen", S_FROZEN, 28'h0);
        check();
        rst = 1'b0;

        // Up-count 1000 ticks from reset.
        en = 1'b1;
        step(1);
        expect_val("idle_to_run", S_STATE, 28'd1);
        expect_val("run_first_count", S_COUNT, 28'h0);
        check();
        step(1000);
        expect_val("up1000_count", S_COUNT, 28'h0001000);
        expect_val("up1000_disp", S_DISP, 28'h0000100);
        expect_val("up1000_state", S_STATE, 28'd1);
        expect_val("up1000_wrap", S_WRAP, 28'h0);
        check();

        // Rollover from all-max, both prescaler settings.
        load = 1'b1; preset = 28'h9959999;
        step(1);
        load = 1'b0;
        expect_val("max_loaded", S_COUNT, 28'h9959999);
        expect_val("max_wrap_lo", S_WRAP, 28'h0);
        expect_val("max_loaded4", S_COUNT4, 28'h9959999);
        check();
        step(1);
        expect_val("roll_count", S_COUNT, 28'h0);
        expect_val("roll_wrap", S_WRAP, 28'h1);
        expect_val("roll_state", S_STATE, 28'd1);
        expect_val("roll4_not_yet", S_COUNT4, 28'h9959999);
        check();
        step(1);
        expect_val("roll_next_count", S_COUNT, 28'h1);
        expect_val("roll_wrap_pulse", S_WRAP, 28'h0);
        check();
        step(1);
        expect_val("roll4_edge3", S_COUNT4, 28'h9959999);
        expect_val("roll4_wrap_lo", S_WRAP4, 28'h0);
        check();
        step(1);
        expect_val("roll4_count", S_COUNT4, 28'h0);
        expect_val("roll4_wrap", S_WRAP4, 28'h1);
        check();
        step(1);
        expect_val("roll4_wrap_pulse", S_WRAP4, 28'h0);
        expect_val("roll4_state", S_STATE4, 28'd1);
        check();

        // Down-count to zero, DONE is sticky, load leaves it.
        load = 1'b1; preset = 28'h0000003; mode = 1'b1;
        step(1);
        load = 1'b0;
        expect_val("down_loaded", S_COUNT, 28'h0000003);
        check();
        step(2);
        expect_val("down_one", S_COUNT, 28'h0000001);
        expect_val("down_not_done", S_DONE, 28'h0);
        check();
        step(1);
        expect_val("down_zero", S_COUNT, 28'h0);
        expect_val("down_done", S_DONE, 28'h1);
        expect_val("down_state", S_STATE, 28'd3);
        check();
        step(5);
        expect_val("done_hold_count", S_COUNT, 28'h0);
        expect_val("done_hold_flag", S_DONE, 28'h1);
        expect_val("done_hold_state", S_STATE, 28'd3);
        check();
        load = 1'b1; preset = 28'h0000500;
        step(1);
        load = 1'b0;
        expect_val("reload_state", S_STATE, 28'd1);
        expect_val("reload_done", S_DONE, 28'h0);
        expect_val("reload_count", S_COUNT, 28'h0000500);
        check();

        // Lap capture and release.
        mode = 1'b0; load = 1'b1; preset = 28'h0002495;
        step(1);
        load = 1'b0;
        step(5);
        expect_val("lap_pre_count", S_COUNT, 28'h0002500);
        check();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        expect_val("lap_frozen", S_FROZEN, 28'h1);
        expect_val("lap_disp", S_DISP, 28'h0000250);
        expect_val("lap_count_runs", S_COUNT, 28'h0002501);
        check();
        step(20);
        expect_val("lap_hold_disp", S_DISP, 28'h0000250);
        expect_val("lap_hold_count", S_COUNT, 28'h0002521);
        check();
        lap = 1'b1; lap_clr = 1'b1;
        step(1);
        lap = 1'b0; lap_clr = 1'b0;
        expect_val("lapclr_frozen", S_FROZEN, 28'h0);
        expect_val("lapclr_disp", S_DISP, 28'h0000252);
        check();
        step(10);
        expect_val("lapclr_track", S_DISP, 28'h0000253);
        check();

        // Preset sanitising, then pause/resume.
        load = 1'b1; preset = 28'hF2745_6C;
        step(1);
        load = 1'b0;
        expect_val("sanitise", S_COUNT, 28'h9254569);
        check();
        step(1);
        expect_val("san_next", S_COUNT, 28'h9254570);
        check();
        en = 1'b0;
        step(1);
        expect_val("pause_state", S_STATE, 28'd2);
        expect_val("pause_last_tick", S_COUNT, 28'h9254571);
        check();
        step(5);
        expect_val("pause_hold", S_COUNT, 28'h9254571);
        expect_val("pause_hold_state", S_STATE, 28'd2);
        check();
        en = 1'b1;
        step(1);
        expect_val("resume_state", S_STATE, 28'd1);
        expect_val("resume_no_tick", S_COUNT, 28'h9254571);
        check();
        step(1);
        expect_val("resume_tick", S_COUNT, 28'h9254572);
        check();

        // Asynchronous reset while frozen and running.
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        expect_val("pre_rst_frozen", S_FROZEN, 28'h1);
        check();
        #2 rst = 1'b1;
        #1;
        expect_val("arst_count", S_COUNT, 28'h0);
        expect_val("arst_disp", S_DISP, 28'h0);
        expect_val("arst_state", S_STATE, 28'd0);
        expect_val("arst_done", S_DONE, 28'h0);
        expect_val("arst_wrap", S_WRAP, 28'h0);
        expect_val("arst_frozen", S_FROZEN, 28'h0);
        expect_val("arst_count4", S_COUNT4, 28'h0);
        check();
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
